// File: rtl/video_fetch_fifo.sv
// Framebuffer fetch engine for the 1-bpp display path: reads 32-bit words from
// the memory bus into a small FIFO and presents them a byte at a time.
// Each frame restarts at base_addr on the synchronized falling edge of vsync_n.
module video_fetch_fifo #(
  parameter int ADDR_WIDTH  = 30,
  parameter int DEPTH_LOG2  = 4,
  parameter int FRAME_WORDS = 9600
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  addr_strobe,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  data_ready,
  input  logic [31:0]           data_in,
  input  logic                  vsync_n,
  input  logic                  rd,
  output logic [7:0]            data_out,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WL_W  = $clog2(FRAME_WORDS + 1);
  localparam logic [WL_W-1:0] WL_INIT = WL_W'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_vs_meta, r_vs_sync, r_vs_d;
  logic [ADDR_WIDTH-1:0]  r_fetch_ptr, r_addr;
  logic [WL_W-1:0]        r_words_left;
  logic [31:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]    r_count;
  logic [1:0]             r_byte_idx;
  logic                   r_underflow;
  logic                   w_frame_start, w_issue, w_push, w_pop, w_rd_ok, w_empty;
  logic [31:0]            w_head;

  // vsync_n synchronizer plus edge-detect flop; idle-high so reset never fakes an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_d    <= 1'b1;
    end else begin
      r_vs_meta <= vsync_n;
      r_vs_sync <= r_vs_meta;
      r_vs_d    <= r_vs_sync;
    end
  end

  assign w_frame_start = r_vs_d & ~r_vs_sync;
  assign w_empty       = (r_count == '0);
  // A frame start swallows any push or rd landing in the same cycle
  assign w_push        = (r_state == S_REQ) & data_ready & ~w_frame_start;
  assign w_rd_ok       = rd & ~w_empty & ~w_frame_start;
  assign w_pop         = w_rd_ok & (r_byte_idx == 2'd3);

  // Fetch FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Fetch FSM next state; count MSB clear means the FIFO has room for one more word
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_count[DEPTH_LOG2] && (r_words_left != '0) && !w_frame_start) begin
          w_state_nxt = S_REQ;
          w_issue     = 1'b1;
        end
      end
      S_REQ: begin
        if (data_ready)         w_state_nxt = S_IDLE;
        else if (w_frame_start) w_state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (data_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign addr_strobe = (r_state != S_IDLE);
  assign addr        = r_addr;

  // Request address is latched at issue so a frame restart cannot move an open request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_addr <= '0;
    else if (w_issue) r_addr <= r_fetch_ptr;
  end

  // Fetch pointer and frame word budget; reload wins over an accepted word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_ptr  <= '0;
      r_words_left <= '0;
    end else if (w_frame_start) begin
      r_fetch_ptr  <= base_addr;
      r_words_left <= WL_INIT;
    end else if (w_push) begin
      r_fetch_ptr  <= r_fetch_ptr + 1'b1;
      r_words_left <= r_words_left - 1'b1;
    end
  end

  // FIFO storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  // FIFO pointers, occupancy and byte cursor within the head word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
    end else if (w_frame_start) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
    end else begin
      if (w_push)  r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_rd_ok) r_byte_idx <= r_byte_idx + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // One-cycle underflow flag for a rd that found nothing to consume
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_underflow <= 1'b0;
    else          r_underflow <= rd & w_empty & ~w_frame_start;
  end

  assign underflow = r_underflow;
  assign w_head    = r_mem[r_rd_ptr];
  assign data_out  = w_empty ? 8'h00 : w_head[{r_byte_idx, 3'b000} +: 8];

endmodule

// File: tb/tb_video_fetch_fifo.sv
// Directed bench for video_fetch_fifo: two instances (deep FIFO with a 4-word
// frame, and a 4-deep FIFO with a 16-word frame) each behind a simple bus
// responder that acks two cycles after the strobe with address-derived data.
module tb_video_fetch_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [29:0] base_addr = 30'h100;
  logic        vsync_n = 1'b1;

  logic        strobe_a, strobe_b, dr_a, dr_b, rd_a, rd_b, uf_a, uf_b;
  logic [29:0] addr_a, addr_b;
  logic [31:0] din_a, din_b;
  logic [7:0]  data_a, data_b;
  logic        en_a, en_b;
  int          wcnt_a, wcnt_b;
  logic [29:0] log_a[$];
  logic [29:0] log_b[$];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Word n of the frame holds bytes (4n+j+1)*0x11 : 0x44332211, 0x88776655, ...
  function automatic logic [31:0] mkword(input logic [29:0] a);
    logic [31:0] w;
    int n;
    n = int'(a - 30'h100);
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((4*n + j + 1) * 17);
    return w;
  endfunction

  assign din_a = mkword(addr_a);
  assign din_b = mkword(addr_b);

  video_fetch_fifo #(.ADDR_WIDTH(30), .DEPTH_LOG2(4), .FRAME_WORDS(4)) u_a (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .addr_strobe(strobe_a), .addr(addr_a), .data_ready(dr_a), .data_in(din_a),
    .vsync_n(vsync_n), .rd(rd_a), .data_out(data_a), .underflow(uf_a));

  video_fetch_fifo #(.ADDR_WIDTH(30), .DEPTH_LOG2(2), .FRAME_WORDS(16)) u_b (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .addr_strobe(strobe_b), .addr(addr_b), .data_ready(dr_b), .data_in(din_b),
    .vsync_n(vsync_n), .rd(rd_b), .data_out(data_b), .underflow(uf_b));

  // Bus responders: ack on the second cycle of a strobe, log acked addresses
  always @(negedge clk) begin
    if (!en_a) begin wcnt_a = 0; dr_a = 1'b0; end
    else if (dr_a) begin dr_a = 1'b0; wcnt_a = 0; end
    else if (strobe_a) begin
      wcnt_a++;
      if (wcnt_a == 2) begin dr_a = 1'b1; log_a.push_back(addr_a); end
    end
  end

  always @(negedge clk) begin
    if (!en_b) begin wcnt_b = 0; dr_b = 1'b0; end
    else if (dr_b) begin dr_b = 1'b0; wcnt_b = 0; end
    else if (strobe_b) begin
      wcnt_b++;
      if (wcnt_b == 2) begin dr_b = 1'b1; log_b.push_back(addr_b); end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle rd pulse on instance b; returns at the following negedge
  task automatic rd_pulse_b();
    @(negedge clk) rd_b = 1'b1;
    @(negedge clk) rd_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    dr_a = 1'b0; dr_b = 1'b0; wcnt_a = 0; wcnt_b = 0;
    rd_a = 1'b0; rd_b = 1'b0; en_a = 1'b1; en_b = 1'b1;

    // Reset values
    #1;
    chk("rst_strobe", {31'd0, strobe_b}, 0);
    chk("rst_addr",   {2'd0, addr_b}, 0);
    chk("rst_data",   {24'd0, data_b}, 0);
    chk("rst_uf",     {31'd0, uf_b}, 0);
    idle(3);
    reset_n = 1'b1;
    idle(10);
    chk("no_fetch_before_frame", log_a.size() + log_b.size(), 0);

    // Frame start: both fetch 0x100..0x103
    vsync_n = 1'b0;
    idle(40);
    chk("a_req_cnt", log_a.size(), 4);
    chk("b_req_cnt", log_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("a_req_addr", {2'd0, log_a[i]}, 32'h100 + i);
      chk("b_req_addr", {2'd0, log_b[i]}, 32'h100 + i);
    end
    chk("b_full_idle", {31'd0, strobe_b}, 0);
    chk("a_data0", {24'd0, data_a}, 32'h11);
    chk("b_data0", {24'd0, data_b}, 32'h11);
    idle(20);
    chk("a_frame_stop", log_a.size(), 4);
    chk("a_strobe_off", {31'd0, strobe_a}, 0);

    // Byte stepping across a word boundary; pop after the 4th rd frees one slot
    begin
      logic [7:0] exp2 [5];
      exp2 = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 5; i++) begin
        rd_pulse_b();
        chk("rd_byte", {24'd0, data_b}, {24'd0, exp2[i]});
        if (i == 3) chk("count_after_pop", {27'd0, u_b.r_count}, 3);
        idle(3);
      end
    end
    idle(10);
    chk("one_more_req", log_b.size(), 5);
    chk("one_more_addr", {2'd0, log_b[4]}, 32'h104);
    chk("refull_idle", {31'd0, strobe_b}, 0);

    // Drain with the bus stalled, then underflow
    en_b = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rd_pulse_b();
      if (i == 13) chk("last_byte", {24'd0, data_b}, 32'h54);
    end
    chk("drained_data", {24'd0, data_b}, 0);
    rd_pulse_b();
    chk("uf_pulse", {31'd0, uf_b}, 1);
    chk("uf_data", {24'd0, data_b}, 0);
    chk("uf_byte_idx", {30'd0, u_b.r_byte_idx}, 0);
    idle(1);
    chk("uf_one_clk", {31'd0, uf_b}, 0);
    chk("stall_strobe", {31'd0, strobe_b}, 1);
    chk("stall_addr", {2'd0, addr_b}, 32'h105);

    // Frame restart while the 0x105 request is open
    vsync_n = 1'b1;
    idle(6);
    vsync_n = 1'b0;
    idle(8);
    chk("disc_strobe", {31'd0, strobe_b}, 1);
    chk("disc_addr", {2'd0, addr_b}, 32'h105);
    chk("disc_count", {27'd0, u_b.r_count}, 0);
    en_b = 1'b1;
    for (int i = 0; i < 40 && log_b.size() < 7; i++) idle(1);
    chk("disc_wait", {31'd0, log_b.size() >= 7}, 1);
    idle(20);
    chk("disc_ack_addr", {2'd0, log_b[5]}, 32'h105);
    chk("restart_addr", {2'd0, log_b[6]}, 32'h100);
    chk("restart_cnt", log_b.size(), 10);
    chk("restart_data", {24'd0, data_b}, 32'h11);
    chk("a_restart_cnt", log_a.size(), 8);
    chk("a_restart_data", {24'd0, data_a}, 32'h11);

    // Async reset while a request is open
    en_b = 1'b0;
    for (int i = 0; i < 4; i++) rd_pulse_b();
    for (int i = 0; i < 20 && !strobe_b; i++) idle(1);
    chk("pre_rst_strobe", {31'd0, strobe_b}, 1);
    chk("pre_rst_addr", {2'd0, addr_b}, 32'h104);
    @(negedge clk);
    #2;
    vsync_n = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async_strobe", {31'd0, strobe_b}, 0);
    chk("async_addr", {2'd0, addr_b}, 0);
    chk("async_data", {24'd0, data_b}, 0);
    idle(3);
    reset_n = 1'b1;
    en_b = 1'b1;
    idle(20);
    chk("post_rst_no_req", log_b.size(), 10);
    chk("post_rst_strobe", {31'd0, strobe_b}, 0);
    vsync_n = 1'b0;
    idle(30);
    chk("post_rst_frame_cnt", log_b.size(), 14);
    chk("post_rst_frame_addr", {2'd0, log_b[10]}, 32'h100);
    chk("post_rst_data", {24'd0, data_b}, 32'h11);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
